gpu_csr_bank: RTL and testbench
===============================

GPU_CSR_BANK -- requirements
Module: gpu_csr_bank

Interface
REQ-001 SHALL have parameter BYTES_PER_REG, default 4, bytes per register; WIDTH = 8*BYTES_PER_REG (derived).
REQ-002 SHALL have parameter REG_COUNT, default 32, total register slots (min 4); ADDR_BITS = $clog2(REG_COUNT*BYTES_PER_REG) (derived).
REQ-003 SHALL have parameter EXPORT_COUNT, default 8, general registers exported on regs_o (1..REG_COUNT-3).
REQ-004 SHALL have parameter ID_VALUE, default 32'h4750_0001, read-only block ID (truncated/zero-extended to WIDTH).
REQ-005 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port en_i, input, 1, access enable.
REQ-008 SHALL have port addr_i, input, ADDR_BITS, byte address.
REQ-009 SHALL have port din_i, input, WIDTH, write data.
REQ-010 SHALL have port we_i, input, BYTES_PER_REG, per-byte write enable.
REQ-011 SHALL have port dout_o, output, WIDTH, registered read data.
REQ-012 SHALL have port regs_o, output, EXPORT_COUNT*WIDTH, registers 0..EXPORT_COUNT-1 flattened, reg k at [k*WIDTH +: WIDTH].
REQ-013 SHALL have port done_i, input, 1, single-cycle completion pulse from GPU engine.
REQ-014 SHALL have port start_o, output, 1, single-cycle launch pulse to GPU engine.
REQ-015 SHALL have port busy_o, output, 1, high while engine in RUN.
REQ-016 SHALL have port irq_o, output, 1, level interrupt.

Function
REQ-017 Register index = addr_i >> $clog2(BYTES_PER_REG); low address bits SHALL be ignored.
REQ-018 Map: 0..REG_COUNT-4 general RW; CTRL = REG_COUNT-3; STATUS = REG_COUNT-2; ID = REG_COUNT-1.
REQ-019 General write: when en_i, byte j SHALL update only where we_i[j]=1; other bytes hold.
REQ-020 Read: when en_i, dout_o SHALL load the pre-write value of the addressed register at the next edge (1-cycle latency, read-before-write); when en_i=0, dout_o SHALL hold.
REQ-021 Index >= REG_COUNT (non-power-of-2 REG_COUNT): writes ignored, dout_o SHALL load 0.
REQ-022 CTRL bit0 START: write-1 (byte 0 enabled) SHALL request launch; SHALL read 0 always. CTRL bit1 IRQ_EN: RW stored bit. Other CTRL bits read 0.
REQ-023 STATUS bit0 BUSY read-only; bit1 DONE sticky W1C; bit2 ERR sticky W1C; others read 0; writes to BUSY ignored.
REQ-024 ID SHALL read ID_VALUE; writes ignored.
REQ-025 FSM states IDLE, RUN. IDLE + START write -> RUN, start_o=1 for exactly the following cycle.
REQ-026 RUN + done_i -> IDLE, set DONE. done_i in IDLE SHALL be ignored (no DONE set).
REQ-027 START write while RUN SHALL not re-launch; sets ERR; state unchanged.
REQ-028 START write and done_i in same RUN cycle: go IDLE, set DONE, set ERR, no launch.
REQ-029 Same-cycle W1C and hardware set of DONE/ERR: set SHALL win.
REQ-030 busy_o = (state==RUN), registered state only; STATUS.BUSY equals busy_o.
REQ-031 irq_o = IRQ_EN & (DONE | ERR), from registered bits, glitch-free, no extra latency.
REQ-032 regs_o SHALL reflect stored general registers combinationally from flops (write visible cycle after edge).

Reset
REQ-033 rst_ni=0 SHALL asynchronously clear all general registers, CTRL, DONE, ERR, dout_o; FSM to IDLE; start_o, busy_o, irq_o = 0.
REQ-034 Reset asserted mid-RUN SHALL abort to IDLE with no start_o and no DONE set after deassertion.
REQ-035 First edge after rst_ni rises SHALL accept accesses normally.

Verification
REQ-036 Byte write: addr 0x04, din 32'hAABBCCDD, we 4'b0101 over 0 -> reg1 = 32'h00BB00DD; readback dout_o = 32'h00BB00DD one cycle after read; regs_o[63:32] matches.
REQ-037 Launch: write CTRL=32'h3 -> start_o high one cycle, busy_o=1; done_i pulse -> busy_o=0, STATUS reads 32'h2, irq_o=1; write STATUS=32'h2 -> irq_o=0.
REQ-038 Double start: START in RUN -> no second start_o, STATUS.ERR=1, busy_o stays 1.
REQ-039 Collisions: done_i + START same cycle -> IDLE, STATUS=32'h6; W1C of DONE same cycle as done_i -> DONE remains 1.
REQ-040 Read-before-write: write 32'h1234 to reg2 holding 32'h5555 with en_i -> dout_o = 32'h5555; ID read -> ID_VALUE; ID write ignored.
REQ-041 Async reset mid-RUN, between edges -> all outputs 0 immediately, FSM IDLE, later done_i ignored.

Source files
------------

// File: rtl/gpu_csr_bank.sv
// Control/status register bank for a GPU engine: byte-writable general registers,
// CTRL/STATUS/ID registers and a two-state launch FSM driving start/busy/irq.
module gpu_csr_bank #(
    parameter int BYTES_PER_REG = 4,
    parameter int REG_COUNT     = 32,
    parameter int EXPORT_COUNT  = 8,
    parameter     ID_VALUE      = 32'h4750_0001,
    localparam int WIDTH        = 8 * BYTES_PER_REG,
    localparam int ADDR_BITS    = $clog2(REG_COUNT * BYTES_PER_REG)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic [ADDR_BITS-1:0]          addr_i,
    input  logic [WIDTH-1:0]              din_i,
    input  logic [BYTES_PER_REG-1:0]      we_i,
    output logic [WIDTH-1:0]              dout_o,
    output logic [EXPORT_COUNT*WIDTH-1:0] regs_o,
    input  logic                          done_i,
    output logic                          start_o,
    output logic                          busy_o,
    output logic                          irq_o
);

    localparam int NGEN     = REG_COUNT - 3;
    localparam int IDX_BITS = $clog2(BYTES_PER_REG);
    localparam logic [31:0] CTRL_IDX   = 32'(REG_COUNT - 3);
    localparam logic [31:0] STATUS_IDX = 32'(REG_COUNT - 2);
    localparam logic [31:0] ID_IDX     = 32'(REG_COUNT - 1);
    localparam logic [WIDTH-1:0] ID_W  = WIDTH'(ID_VALUE);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_gen [NGEN];
    logic [WIDTH-1:0]   r_dout;
    logic               r_irq_en;
    logic               r_done;
    logic               r_err;
    logic               r_start;
    logic               w_start_next;
    logic               w_done_set;
    logic               w_err_set;
    logic [31:0]        w_idx;
    logic               w_busy;
    logic               w_ctrl_wr;
    logic               w_status_wr;
    logic               w_start_wr;
    logic               w_done_clr;
    logic               w_err_clr;
    logic [WIDTH-1:0]   w_rd_data;

    assign w_idx       = 32'(addr_i >> IDX_BITS);
    assign w_busy      = (r_state == RUN);
    assign w_ctrl_wr   = en_i && (w_idx == CTRL_IDX) && we_i[0];
    assign w_status_wr = en_i && (w_idx == STATUS_IDX) && we_i[0];
    assign w_start_wr  = w_ctrl_wr && din_i[0];
    assign w_done_clr  = w_status_wr && din_i[1];
    assign w_err_clr   = w_status_wr && din_i[2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_start <= w_start_next;
        end
    end

    // A START write while running is an error, even when it coincides with done_i.
    always_comb begin
        w_state_next = r_state;
        w_start_next = 1'b0;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_wr) begin
                    w_state_next = RUN;
                    w_start_next = 1'b1;
                end
            end
            RUN: begin
                w_err_set = w_start_wr;
                if (done_i) begin
                    w_state_next = IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NGEN; k++) begin
            if (w_idx == 32'(k)) w_rd_data = r_gen[k];
        end
        if (w_idx == CTRL_IDX) begin
            w_rd_data[1] = r_irq_en;
        end else if (w_idx == STATUS_IDX) begin
            w_rd_data[2:0] = {r_err, r_done, w_busy};
        end else if (w_idx == ID_IDX) begin
            w_rd_data = ID_W;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NGEN; k++) r_gen[k] <= '0;
        end else begin
            for (int k = 0; k < NGEN; k++) begin
                for (int j = 0; j < BYTES_PER_REG; j++) begin
                    if (en_i && we_i[j] && (w_idx == 32'(k)))
                        r_gen[k][8*j +: 8] <= din_i[8*j +: 8];
                end
            end
        end
    end

    // Hardware set takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dout   <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (en_i) r_dout <= w_rd_data;
            if (w_ctrl_wr) r_irq_en <= din_i[1];
            r_done <= w_done_set | (r_done & ~w_done_clr);
            r_err  <= w_err_set  | (r_err  & ~w_err_clr);
        end
    end

    generate
        for (genvar gi = 0; gi < EXPORT_COUNT; gi++) begin : g_export
            assign regs_o[gi*WIDTH +: WIDTH] = r_gen[gi];
        end
    endgenerate

    assign dout_o  = r_dout;
    assign start_o = r_start;
    assign busy_o  = w_busy;
    assign irq_o   = r_irq_en & (r_done | r_err);

endmodule

// File: tb/tb_gpu_csr_bank.sv
// Self-checking bench for gpu_csr_bank: directed scenarios plus randomized traffic
// compared against a register-map level reference model.
module tb_gpu_csr_bank;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         en_i;
    logic [6:0]   addr_i;
    logic [31:0]  din_i;
    logic [3:0]   we_i;
    logic [31:0]  dout_o;
    logic [255:0] regs_o;
    logic         done_i;
    logic         start_o;
    logic         busy_o;
    logic         irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents and status flags by name.
    logic [31:0] m_regs [29];
    logic        m_irq_en, m_done, m_err, m_busy, m_start;
    logic [31:0] m_dout;

    gpu_csr_bank dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .addr_i (addr_i),
        .din_i  (din_i),
        .we_i   (we_i),
        .dout_o (dout_o),
        .regs_o (regs_o),
        .done_i (done_i),
        .start_o(start_o),
        .busy_o (busy_o),
        .irq_o  (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        for (int k = 0; k < 29; k++) m_regs[k] = 32'h0;
        m_irq_en = 0; m_done = 0; m_err = 0; m_busy = 0; m_start = 0;
        m_dout = 32'h0;
    endtask

    function automatic logic [31:0] model_read(input int idx);
        if (idx < 29)  return m_regs[idx];
        if (idx == 29) return {30'h0, m_irq_en, 1'b0};
        if (idx == 30) return {29'h0, m_err, m_done, m_busy};
        if (idx == 31) return 32'h4750_0001;
        return 32'h0;
    endfunction

    function automatic logic [255:0] model_export();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = m_regs[k];
        return v;
    endfunction

    task automatic model_step(input logic en, input logic [6:0] addr, input logic [31:0] din,
                              input logic [3:0] we, input logic done);
        int   idx;
        logic start_req, was_busy;
        idx       = int'(addr) >> 2;
        start_req = en && idx == 29 && we[0] && din[0];
        was_busy  = m_busy;
        m_start   = 0;
        if (en) m_dout = model_read(idx);
        if (en && idx == 30 && we[0]) begin
            if (din[1]) m_done = 0;
            if (din[2]) m_err  = 0;
        end
        if (en && idx == 29 && we[0]) m_irq_en = din[1];
        if (en && idx < 29)
            for (int j = 0; j < 4; j++) if (we[j]) m_regs[idx][8*j +: 8] = din[8*j +: 8];
        if (was_busy) begin
            if (start_req) m_err = 1;
            if (done) begin m_busy = 0; m_done = 1; end
        end else if (start_req) begin
            m_busy = 1; m_start = 1;
        end
    endtask

    task automatic drive(input logic en, input logic [6:0] addr, input logic [31:0] din,
                         input logic [3:0] we, input logic done);
        en_i = en; addr_i = addr; din_i = din; we_i = we; done_i = done;
        if (rst_ni) model_step(en, addr, din, we, done);
        @(posedge clk_i);
        #1;
        $display("txn en=%b addr=%h din=%h we=%b done=%b -> dout=%h start=%b busy=%b irq=%b",
                 en, addr, din, we, done, dout_o, start_o, busy_o, irq_o);
        en_i = 0; we_i = 4'h0; done_i = 0;
    endtask

    task automatic test_reset();
        n_checks++; if (dout_o !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want %h", dout_o, 32'h0); end
        n_checks++; if (regs_o !== 256'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", regs_o); end
        n_checks++; if ({start_o, busy_o, irq_o} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b want 000", {start_o, busy_o, irq_o}); end
    endtask

    task automatic test_byte_write();
        drive(1, 7'h04, 32'hAABBCCDD, 4'b0101, 0);
        n_checks++; if (regs_o[63:32] !== 32'h00BB00DD) begin n_fail++; $display("FAIL byte_regs: got %h want %h", regs_o[63:32], 32'h00BB00DD); end
        drive(1, 7'h07, 32'h0, 4'b0000, 0);
        n_checks++; if (dout_o !== 32'h00BB00DD) begin n_fail++; $display("FAIL byte_read: got %h want %h", dout_o, 32'h00BB00DD); end
    endtask

    task automatic test_launch();
        drive(1, 7'h74, 32'h3, 4'hF, 0);
        n_checks++; if ({start_o, busy_o} !== 2'b11) begin n_fail++; $display("FAIL launch_start: got %b want 11", {start_o, busy_o}); end
        drive(0, 7'h0, 32'h0, 4'h0, 0);
        n_checks++; if ({start_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL launch_pulse: got %b want 01", {start_o, busy_o}); end
        drive(0, 7'h0, 32'h0, 4'h0, 1);
        n_checks++; if ({busy_o, irq_o} !== 2'b01) begin n_fail++; $display("FAIL launch_done: got %b want 01", {busy_o, irq_o}); end
        drive(1, 7'h78, 32'h0, 4'h0, 0);
        n_checks++; if (dout_o !== 32'h2) begin n_fail++; $display("FAIL launch_status: got %h want %h", dout_o, 32'h2); end
        drive(1, 7'h78, 32'h2, 4'hF, 0);
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL launch_w1c: got %b want 0", irq_o); end
    endtask

    task automatic test_double_start();
        drive(1, 7'h74, 32'h3, 4'hF, 0);
        drive(1, 7'h74, 32'h3, 4'hF, 0);
        n_checks++; if ({start_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL dbl_start: got %b want 01", {start_o, busy_o}); end
        drive(1, 7'h78, 32'h0, 4'h0, 0);
        n_checks++; if (dout_o !== 32'h5) begin n_fail++; $display("FAIL dbl_status: got %h want %h", dout_o, 32'h5); end
    endtask

    task automatic test_collisions();
        drive(1, 7'h78, 32'h4, 4'hF, 0);
        drive(1, 7'h74, 32'h3, 4'hF, 1);
        n_checks++; if ({start_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL col_idle: got %b want 00", {start_o, busy_o}); end
        drive(1, 7'h78, 32'h0, 4'h0, 0);
        n_checks++; if (dout_o !== 32'h6) begin n_fail++; $display("FAIL col_status: got %h want %h", dout_o, 32'h6); end
        drive(1, 7'h78, 32'h6, 4'hF, 0);
        drive(1, 7'h74, 32'h3, 4'hF, 0);
        drive(1, 7'h78, 32'h2, 4'hF, 1);
        drive(1, 7'h78, 32'h0, 4'h0, 0);
        n_checks++; if (dout_o !== 32'h2) begin n_fail++; $display("FAIL col_setwins: got %h want %h", dout_o, 32'h2); end
        drive(1, 7'h78, 32'h6, 4'hF, 0);
    endtask

    task automatic test_rbw_id();
        drive(1, 7'h08, 32'h5555, 4'hF, 0);
        drive(1, 7'h08, 32'h1234, 4'hF, 0);
        n_checks++; if (dout_o !== 32'h5555) begin n_fail++; $display("FAIL rbw_old: got %h want %h", dout_o, 32'h5555); end
        drive(1, 7'h08, 32'h0, 4'h0, 0);
        n_checks++; if (dout_o !== 32'h1234) begin n_fail++; $display("FAIL rbw_new: got %h want %h", dout_o, 32'h1234); end
        drive(1, 7'h7C, 32'hFFFFFFFF, 4'hF, 0);
        drive(1, 7'h7D, 32'h0, 4'h0, 0);
        n_checks++; if (dout_o !== 32'h4750_0001) begin n_fail++; $display("FAIL id_read: got %h want %h", dout_o, 32'h4750_0001); end
        drive(0, 7'h00, 32'h0, 4'h0, 0);
        n_checks++; if (dout_o !== 32'h4750_0001) begin n_fail++; $display("FAIL dout_hold: got %h want %h", dout_o, 32'h4750_0001); end
    endtask

    task automatic test_async_reset();
        drive(1, 7'h74, 32'h3, 4'hF, 0);
        drive(1, 7'h74, 32'h3, 4'hF, 0);
        n_checks++; if ({busy_o, irq_o} !== 2'b11) begin n_fail++; $display("FAIL arst_pre: got %b want 11", {busy_o, irq_o}); end
        #3 rst_ni = 0;
        #1;
        model_reset();
        n_checks++; if ({start_o, busy_o, irq_o} !== 3'b000) begin n_fail++; $display("FAIL arst_ctl: got %b want 000", {start_o, busy_o, irq_o}); end
        n_checks++; if (dout_o !== 32'h0 || regs_o !== 256'h0) begin n_fail++; $display("FAIL arst_data: got dout=%h regs=%h want 0", dout_o, regs_o); end
        drive(0, 7'h0, 32'h0, 4'h0, 0);
        rst_ni = 1;
        drive(0, 7'h0, 32'h0, 4'h0, 1);
        n_checks++; if ({start_o, busy_o, irq_o} !== 3'b000) begin n_fail++; $display("FAIL arst_after: got %b want 000", {start_o, busy_o, irq_o}); end
        drive(1, 7'h78, 32'h0, 4'h0, 0);
        n_checks++; if (dout_o !== 32'h0) begin n_fail++; $display("FAIL arst_status: got %h want %h", dout_o, 32'h0); end
    endtask

    task automatic test_random();
        int          sel, idx;
        logic        en, done;
        logic [6:0]  addr;
        logic [31:0] din;
        logic [3:0]  we;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      idx = $urandom_range(0, 7);
            else if (sel < 7) idx = $urandom_range(0, 31);
            else              idx = $urandom_range(29, 31);
            addr = 7'(idx * 4 + $urandom_range(0, 3));
            din  = $urandom;
            we   = 4'($urandom_range(0, 15));
            en   = ($urandom_range(0, 4) != 0);
            done = ($urandom_range(0, 5) == 0);
            drive(en, addr, din, we, done);
            n_checks++; if (dout_o !== m_dout) begin n_fail++; $display("FAIL rnd_dout[%0d]: got %h want %h", n, dout_o, m_dout); end
            n_checks++; if (start_o !== m_start) begin n_fail++; $display("FAIL rnd_start[%0d]: got %b want %b", n, start_o, m_start); end
            n_checks++; if (busy_o !== m_busy) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, busy_o, m_busy); end
            n_checks++; if (irq_o !== (m_irq_en & (m_done | m_err))) begin n_fail++; $display("FAIL rnd_irq[%0d]: got %b want %b", n, irq_o, m_irq_en & (m_done | m_err)); end
            n_checks++; if (regs_o !== model_export()) begin n_fail++; $display("FAIL rnd_regs[%0d]: got %h want %h", n, regs_o, model_export()); end
        end
    endtask

    initial begin
        rst_ni = 0; en_i = 0; addr_i = 7'h0; din_i = 32'h0; we_i = 4'h0; done_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        test_reset();
        test_byte_write();
        test_launch();
        test_double_start();
        test_collisions();
        test_rbw_id();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
